bus_arbiter: RTL and testbench

// Round-robin arbiter for the shared tri-state 16-bit bus. Up to NUM_REQ masters compete
// for the right to drive the bus: the CPU controller, a program loader and debug/DMA ports.

---
 rtl/bus_arbiter_if.sv | 41 ++++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Handshake bundle between the bus masters and the round-robin bus arbiter.
//
// Signals:
//   req      [NUM_REQ]  per-master request, held high while the bus is wanted
//   gnt      [NUM_REQ]  one-hot grant, gnt[i]=1 -> master i may drive the bus
//   owner    [OWNER_W]  index of the current or most recently granted master
//   busy     [1]        arbiter is in a tenure or in the turnaround cycle
//   preempt  [1]        final cycle of a tenure cut short by contention
//
// Modports:
//   master : requester side (drives req, observes everything else)
//   slave  : arbiter side (observes req, drives grant/status)
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [OWNER_W-1:0] owner;
  logic               busy;
  logic               preempt;

  modport master (
    output req,
    input  gnt,
    input  owner,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output owner,
    output busy,
    output preempt
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared tri-state 16-bit bus. One master owns the
// bus at a time; under contention a tenure is capped at MAX_HOLD cycles. Every
// change of owner passes through a single no-grant turnaround cycle so that two
// tri-state drivers never overlap.
//
// Parameters:
//   NUM_REQ   number of requesters (2..16)
//   OWNER_W   width of the owner index, 2**OWNER_W >= NUM_REQ
//   MAX_HOLD  tenure cap in cycles while another request waits, 0 = unlimited
//
// Ports:
//   clk   in  system clock, all state on the rising edge
//   rst   in  synchronous reset, active-high
//   bus   slave modport of bus_arbiter_if (req in; gnt/owner/busy/preempt out)
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int OWNER_W  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  // Counter must be able to hold MAX_HOLD itself (it saturates there).
  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [OWNER_W-1:0] owner_reg, owner_next;
  logic [OWNER_W-1:0] last_reg, last_next;
  logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

  // -------------------------------------------------------------------------
  // Round-robin pick. Doubling the request vector and shifting it right by
  // last+1 lines bit j up with requester (last+1+j) mod NUM_REQ, so the
  // lowest set bit of the rotated window is the winner.
  // -------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 arb_valid;
  logic [OWNER_W-1:0]   arb_idx;

  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl >> (int'(last_reg) + 1);

  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    // Scan from the far end so the nearest requester is the final assignment.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        arb_valid = 1'b1;
        arb_idx   = OWNER_W'((int'(last_reg) + 1 + j) % NUM_REQ);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Owner / contention detection. While in GRANT the grant register is
  // onehot(owner), so masking req with it avoids a variable-width index.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] other_mask;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_other
    assign other_mask[gi] = bus.req[gi] & ~gnt_reg[gi];
  end

  logic owner_req;
  logic other_req;
  logic cap_reached;
  logic preempt_hit;

  assign owner_req   = |(bus.req & gnt_reg);
  assign other_req   = |other_mask;
  assign cap_reached = (MAX_HOLD != 0) && (hold_cnt_reg == HC_W'(MAX_HOLD - 1));
  // A simultaneous voluntary release wins: owner_req must still be high.
  assign preempt_hit = (state_reg == GRANT) && owner_req && other_req && cap_reached;

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;

    unique case (state_reg)
      IDLE, TURN: begin
        // The pointer was moved to the outgoing owner on entry to TURN, so
        // the same scan serves both states.
        if (arb_valid) begin
          state_next    = GRANT;
          gnt_next      = NUM_REQ'(1) << arb_idx;
          owner_next    = arb_idx;
          hold_cnt_next = '0;
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end

      GRANT: begin
        if (!owner_req || preempt_hit) begin
          state_next = TURN;
          gnt_next   = '0;
          last_next  = owner_reg;
        end else if (hold_cnt_reg != HC_W'(MAX_HOLD)) begin
          hold_cnt_next = hold_cnt_reg + HC_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      owner_reg    <= '0;
      last_reg     <= OWNER_W'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.gnt     = gnt_reg;
  assign bus.owner   = owner_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.preempt = preempt_hit;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (NUM_REQ=4, OWNER_W=2, MAX_HOLD=8).
// Directed scenarios followed by random request patterns, all compared against
// a timeline model of bus ownership (holder, tenure length, gap cycle).
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int OWNER_W  = 2;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;

  bus_arbiter_if #(.NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W)) bus ();

  bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OWNER_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Ownership timeline model
  int m_holder = -1;  // master currently granted, -1 when nobody holds the bus
  int m_tenure = 0;   // grant cycles so far in this tenure, counting the current one
  bit m_gap    = 1'b0; // the current cycle is the mandatory turnaround gap
  int m_last   = NUM_REQ - 1;
  int m_owner  = 0;
  bit m_init   = 1'b0;
  int pre_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester after m_last in circular order, or -1.
  function automatic int rr_pick(input logic [3:0] q);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (m_last + k) % NUM_REQ;
      if (q[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // Preempt: the MAX_HOLD-th cycle of a tenure whose owner still wants the bus
  // while someone else is waiting.
  function automatic bit model_preempt(input logic [3:0] q);
    logic [3:0] others;
    if (m_holder < 0 || MAX_HOLD == 0) return 1'b0;
    if (!q[m_holder[1:0]]) return 1'b0;
    others = q & ~(4'b0001 << m_holder);
    return (m_tenure == MAX_HOLD) && (others != 4'b0000);
  endfunction

  function automatic logic [3:0] model_gnt();
    if (m_holder < 0) return 4'b0000;
    return 4'b0001 << m_holder;
  endfunction

  // One clock cycle: apply inputs, check preempt for this cycle, advance the
  // model across the edge, then check registered outputs.
  task automatic step(input logic r, input logic [3:0] q);
    bit exp_pre;
    int w;
    rst     = r;
    bus.req = q;
    #1;
    exp_pre = model_preempt(q);
    if (m_init) begin
      check("preempt", 32'(bus.preempt), 32'(exp_pre));
      if (bus.preempt === 1'b1) pre_seen++;
    end
    @(posedge clk);
    if (r) begin
      m_holder = -1; m_tenure = 0; m_gap = 1'b0;
      m_last = NUM_REQ - 1; m_owner = 0; m_init = 1'b1;
    end else if (m_holder >= 0) begin
      if (!q[m_holder[1:0]] || exp_pre) begin
        m_last   = m_holder;
        m_holder = -1;
        m_gap    = 1'b1;
      end else begin
        m_tenure++;
      end
    end else begin
      m_gap = 1'b0;
      w = rr_pick(q);
      if (w >= 0) begin
        m_holder = w;
        m_owner  = w;
        m_tenure = 1;
      end
    end
    #1;
    check("gnt",    32'(bus.gnt),   32'(model_gnt()));
    check("owner",  32'(bus.owner), 32'(m_owner));
    check("busy",   32'(bus.busy),  32'((m_holder >= 0) || m_gap));
    check("onehot", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  initial begin
    logic [3:0] pat;
    int         len;

    rst     = 1'b1;
    bus.req = 4'b0000;

    // 1: reset with everyone requesting, then first grant goes to master 0
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1111);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_owner", 32'(bus.owner), 32'h0);
    // 4: full contention rotates through all masters
    for (int i = 0; i < 40; i++) step(1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);

    // 2: lone requester keeps the bus, never preempted
    pre_seen = 0;
    for (int i = 0; i < 21; i++) step(1'b0, 4'b0100);
    check("t2_gnt", 32'(bus.gnt), 32'h4);
    check("t2_pre", 32'(pre_seen), 32'd0);
    step(1'b0, 4'b0000);
    check("t2_turn_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 4'b0000);
    check("t2_idle_busy", 32'(bus.busy), 32'd0);

    // 3: two contenders alternate with capped tenures
    pre_seen = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 4'b0011);
    check("t3_pre", 32'(pre_seen), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);

    // 5: master 0 releases early, master 3 follows after a single gap
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1001);
    step(1'b0, 4'b1000);
    check("t5_gap", 32'(bus.gnt), 32'h0);
    step(1'b0, 4'b1000);
    check("t5_gnt", 32'(bus.gnt), 32'h8);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);

    // 6: reset during a tenure, pointer restored
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0010);
    check("t6_gnt1", 32'(bus.gnt), 32'h2);
    step(1'b1, 4'b0010);
    check("t6_rst", 32'(bus.gnt), 32'h0);
    step(1'b0, 4'b0011);
    check("t6_first", 32'(bus.gnt), 32'h1);

    // Random patterns, each held for a random number of cycles
    for (int n = 0; n < 120; n++) begin
      pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) pat = pat ^ 4'($urandom_range(1, 15));
        step(($urandom_range(0, 99) == 0), pat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
